uart_rx_word_pack: RTL and testbench

- Sits directly downstream of the programmable UART receiver in the UART program-loader path.
- Consumes single-cycle byte strobes (rx_dv_i / rx_byte_i) and packs 4 bytes little-endian into 32-bit words.
- Presents each word with an auto-incrementing word address on a valid/ready interface to the instruction-memory write port.
- Detects an end-of-program marker word, flags receive overruns, and optionally discards stale partial words after an inter-byte timeout.

---
 rtl/uart_pack_pkg.sv | 15 +
 rtl/uart_pack_timeout.sv | 24 ++
 rtl/uart_rx_word_pack.sv | 157 +++++++++++++++
 tb/tb_uart_rx_word_pack.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pack_pkg.sv
// Shared types and constants for the UART receive word packer.
package uart_pack_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  typedef logic [$clog2(BYTES_PER_WORD)-1:0] byte_cnt_t;

endpackage

// File: rtl/uart_pack_timeout.sv
// Inter-byte idle timer: down-counter reloaded on clear, single-cycle expiry at terminal count.
module uart_pack_timeout #(
  parameter logic [15:0] TIMEOUT_CLKS = 16'd50000
) (
  input  logic clk,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [15:0] count_q;

  assign expire = enable && !clear && (count_q == 16'd0);

  // Reloading on expiry keeps the timer from wrapping if the collector lingers.
  always_ff @(posedge clk) begin
    if (clear || expire) begin
      count_q <= TIMEOUT_CLKS - 16'd1;
    end else if (enable) begin
      count_q <= count_q - 16'd1;
    end
  end

endmodule

// File: rtl/uart_rx_word_pack.sv
// Packs UART byte strobes little-endian into addressed 32-bit words for the loader.
// Optional inter-byte timeout is built when UART_PACK_TIMEOUT_EN is defined.
//
// state     | meaning
// S_IDLE    | loader disabled or just enabled, bytes ignored
// S_COLLECT | packing bytes into words
// S_DONE    | end-of-program marker seen, bytes ignored until en_i drops
module uart_rx_word_pack
  import uart_pack_pkg::*;
#(
  parameter int                 ADDR_W       = 14,
  parameter logic [ADDR_W-1:0]  START_ADDR   = '0,
  parameter logic [WORD_W-1:0]  EOP_WORD     = 32'h0000_0FFF,
  parameter logic [15:0]        TIMEOUT_CLKS = 16'd50000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              rx_dv_i,
  input  logic [7:0]        rx_byte_i,
  output logic              word_valid_o,
  input  logic              word_ready_i,
  output logic [WORD_W-1:0] word_data_o,
  output logic [ADDR_W-1:0] word_addr_o,
  output logic              done_o,
  output logic              overrun_o,
  output logic              timeout_o
);

  state_t              state_q, state_d;
  byte_cnt_t           cnt_q;
  logic [WORD_W-9:0]   collector_q;
  logic [WORD_W-1:0]   data_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                valid_q;
  logic                overrun_q;

  logic [WORD_W-1:0]   full_word;
  logic                byte_fire;
  logic                word_done;
  logic                is_eop;
  logic                accept;
  logic                load_out;
  logic                drop_word;
  logic                tmo_fire;

  assign byte_fire = en_i && rx_dv_i && (state_q == S_COLLECT);
  assign full_word = {rx_byte_i, collector_q};
  assign word_done = byte_fire && (cnt_q == byte_cnt_t'(BYTES_PER_WORD - 1));
  assign is_eop    = (full_word == EOP_WORD);
  assign accept    = valid_q && word_ready_i;
  assign load_out  = word_done && !is_eop && (!valid_q || accept);
  assign drop_word = word_done && !is_eop && valid_q && !accept;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!en_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    state_d = S_COLLECT;
        S_COLLECT: if (word_done && is_eop) state_d = S_DONE;
        S_DONE:    state_d = S_DONE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // The 4th byte never lands in the collector; it goes straight into full_word.
  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i) begin
      collector_q <= '0;
      cnt_q       <= '0;
    end else if (byte_fire) begin
      cnt_q <= cnt_q + 1'b1;
      case (cnt_q)
        2'd0:    collector_q[7:0]   <= rx_byte_i;
        2'd1:    collector_q[15:8]  <= rx_byte_i;
        2'd2:    collector_q[23:16] <= rx_byte_i;
        default: collector_q        <= '0;
      endcase
    end else if (tmo_fire) begin
      collector_q <= '0;
      cnt_q       <= '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i) begin
      valid_q   <= 1'b0;
      addr_q    <= START_ADDR;
      overrun_q <= 1'b0;
      if (rst_i) begin
        data_q <= '0;
      end
    end else begin
      if (accept) begin
        addr_q <= addr_q + 1'b1;
      end
      if (load_out) begin
        valid_q <= 1'b1;
        data_q  <= full_word;
      end else if (accept) begin
        valid_q <= 1'b0;
      end
      if (drop_word) begin
        overrun_q <= 1'b1;
      end
    end
  end

`ifdef UART_PACK_TIMEOUT_EN
  logic tmo_run;
  logic tmo_clr;
  logic timeout_q;

  assign tmo_run = en_i && (state_q == S_COLLECT) && (cnt_q != '0);
  assign tmo_clr = rst_i || rx_dv_i || !tmo_run;

  uart_pack_timeout #(
    .TIMEOUT_CLKS (TIMEOUT_CLKS)
  ) u_timeout (
    .clk    (clk_i),
    .clear  (tmo_clr),
    .enable (tmo_run),
    .expire (tmo_fire)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i) begin
      timeout_q <= 1'b0;
    end else if (tmo_fire) begin
      timeout_q <= 1'b1;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign tmo_fire  = 1'b0;
  assign timeout_o = 1'b0;
`endif

  assign word_valid_o = valid_q;
  assign word_data_o  = data_q;
  assign word_addr_o  = addr_q;
  assign done_o       = (state_q == S_DONE);
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_uart_rx_word_pack.sv
// Bench for uart_rx_word_pack: vector table plus scoreboard of emitted words.
module tb_uart_rx_word_pack;

`ifdef UART_PACK_TIMEOUT_EN
  localparam logic [15:0] TB_TCLK = 16'd100;
`else
  localparam logic [15:0] TB_TCLK = 16'd50000;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        en_i;
  logic        rx_dv_i;
  logic [7:0]  rx_byte_i;
  logic        word_valid_o;
  logic        word_ready_i;
  logic [31:0] word_data_o;
  logic [13:0] word_addr_o;
  logic        done_o;
  logic        overrun_o;
  logic        timeout_o;

  uart_rx_word_pack #(
    .ADDR_W       (14),
    .START_ADDR   (14'd0),
    .EOP_WORD     (32'h0000_0FFF),
    .TIMEOUT_CLKS (TB_TCLK)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .en_i         (en_i),
    .rx_dv_i      (rx_dv_i),
    .rx_byte_i    (rx_byte_i),
    .word_valid_o (word_valid_o),
    .word_ready_i (word_ready_i),
    .word_data_o  (word_data_o),
    .word_addr_o  (word_addr_o),
    .done_o       (done_o),
    .overrun_o    (overrun_o),
    .timeout_o    (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [7:0]  b3;
    logic [31:0] data;
    logic [13:0] addr;
  } vec_t;

  typedef struct packed {
    logic [31:0] data;
    logic [13:0] addr;
  } exp_t;

  vec_t tbl [4];
  exp_t sb [$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_dv_i   = 1'b1;
    rx_byte_i = b;
    tick();
    rx_dv_i   = 1'b0;
  endtask

  task automatic send4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    send_byte(a);
    send_byte(b);
    send_byte(c);
    send_byte(d);
  endtask

  task automatic push_exp(input logic [31:0] data, input logic [13:0] addr);
    exp_t e;
    e.data = data;
    e.addr = addr;
    sb.push_back(e);
  endtask

  task automatic flush();
    en_i = 1'b0;
    tick();
    en_i = 1'b1;
    tick();
  endtask

  // Handshake observed on the falling edge completes on the following rising edge.
  initial begin
    forever begin
      @(negedge clk_i);
      if (word_valid_o && word_ready_i) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_word: got %h @%h expected none", word_data_o, word_addr_o);
        end else begin
          mon_e = sb.pop_front();
          check("sb_data", word_data_o, mon_e.data);
          check("sb_addr", 32'(word_addr_o), 32'(mon_e.addr));
        end
      end
    end
  end

  initial begin
    tbl[0] = '{b0:8'h78, b1:8'h56, b2:8'h34, b3:8'h12, data:32'h1234_5678, addr:14'd0};
    tbl[1] = '{b0:8'hEF, b1:8'hBE, b2:8'hAD, b3:8'hDE, data:32'hDEAD_BEEF, addr:14'd1};
    tbl[2] = '{b0:8'h00, b1:8'h00, b2:8'h00, b3:8'h00, data:32'h0000_0000, addr:14'd2};
    tbl[3] = '{b0:8'hFF, b1:8'hFF, b2:8'hFF, b3:8'hFF, data:32'hFFFF_FFFF, addr:14'd3};

    rst_i        = 1'b1;
    en_i         = 1'b0;
    rx_dv_i      = 1'b0;
    rx_byte_i    = 8'h00;
    word_ready_i = 1'b0;
    repeat (3) tick();
    check("rst_valid", 32'(word_valid_o), 32'd0);
    check("rst_data", word_data_o, 32'd0);
    check("rst_addr", 32'(word_addr_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_overrun", 32'(overrun_o), 32'd0);
    check("rst_timeout", 32'(timeout_o), 32'd0);

    rst_i        = 1'b0;
    en_i         = 1'b1;
    word_ready_i = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      push_exp(tbl[i].data, tbl[i].addr);
      send_byte(tbl[i].b0);
      send_byte(tbl[i].b1);
      send_byte(tbl[i].b2);
      check("early_valid", 32'(word_valid_o), 32'd0);
      send_byte(tbl[i].b3);
      check("latency_valid", 32'(word_valid_o), 32'd1);
      check("latency_data", word_data_o, tbl[i].data);
    end
    repeat (2) tick();
    check("table_drained", 32'(sb.size()), 32'd0);
    check("table_addr", 32'(word_addr_o), 32'd4);

    // Backpressure: second word is dropped and flagged.
    word_ready_i = 1'b0;
    flush();
    check("flush_addr", 32'(word_addr_o), 32'd0);
    push_exp(32'h0403_0201, 14'd0);
    send4(8'h01, 8'h02, 8'h03, 8'h04);
    send4(8'h05, 8'h06, 8'h07, 8'h08);
    check("bp_valid", 32'(word_valid_o), 32'd1);
    check("bp_data", word_data_o, 32'h0403_0201);
    check("bp_addr", 32'(word_addr_o), 32'd0);
    check("bp_overrun", 32'(overrun_o), 32'd1);
    repeat (3) tick();
    check("bp_hold_data", word_data_o, 32'h0403_0201);
    check("bp_hold_addr", 32'(word_addr_o), 32'd0);
    word_ready_i = 1'b1;
    tick();
    check("bp_acc_valid", 32'(word_valid_o), 32'd0);
    check("bp_acc_addr", 32'(word_addr_o), 32'd1);
    repeat (3) tick();
    check("bp_no_second", 32'(word_valid_o), 32'd0);
    check("bp_overrun_sticky", 32'(overrun_o), 32'd1);

    // 4th byte of word 2 lands on the acceptance of word 1.
    word_ready_i = 1'b0;
    flush();
    check("flush_overrun", 32'(overrun_o), 32'd0);
    push_exp(32'hA4A3_A2A1, 14'd0);
    send4(8'hA1, 8'hA2, 8'hA3, 8'hA4);
    send_byte(8'hB1);
    send_byte(8'hB2);
    send_byte(8'hB3);
    push_exp(32'hB4B3_B2B1, 14'd1);
    word_ready_i = 1'b1;
    send_byte(8'hB4);
    check("sim_valid", 32'(word_valid_o), 32'd1);
    check("sim_data", word_data_o, 32'hB4B3_B2B1);
    check("sim_addr", 32'(word_addr_o), 32'd1);
    check("sim_overrun", 32'(overrun_o), 32'd0);
    tick();
    check("sim_drop_valid", 32'(word_valid_o), 32'd0);
    check("sim_addr2", 32'(word_addr_o), 32'd2);

    // End-of-program marker while a word is still pending.
    word_ready_i = 1'b0;
    flush();
    push_exp(32'hAABB_CCDD, 14'd0);
    send4(8'hDD, 8'hCC, 8'hBB, 8'hAA);
    send4(8'hFF, 8'h0F, 8'h00, 8'h00);
    check("eop_done", 32'(done_o), 32'd1);
    check("eop_pending", 32'(word_valid_o), 32'd1);
    check("eop_data", word_data_o, 32'hAABB_CCDD);
    check("eop_overrun", 32'(overrun_o), 32'd0);
    word_ready_i = 1'b1;
    tick();
    check("eop_drained", 32'(word_valid_o), 32'd0);
    send4(8'h11, 8'h22, 8'h33, 8'h44);
    repeat (2) tick();
    check("eop_ignore_valid", 32'(word_valid_o), 32'd0);
    check("eop_done_sticky", 32'(done_o), 32'd1);
    check("eop_ignore_addr", 32'(word_addr_o), 32'd1);
    flush();
    check("eop_clr_done", 32'(done_o), 32'd0);
    check("eop_clr_addr", 32'(word_addr_o), 32'd0);

    // Flush mid-word; the byte coinciding with en_i low is ignored.
    send_byte(8'h99);
    send_byte(8'h88);
    en_i      = 1'b0;
    rx_dv_i   = 1'b1;
    rx_byte_i = 8'h77;
    tick();
    rx_dv_i = 1'b0;
    en_i    = 1'b1;
    tick();
    push_exp(32'h4433_2211, 14'd0);
    send4(8'h11, 8'h22, 8'h33, 8'h44);
    tick();
    check("flush_word_addr", 32'(word_addr_o), 32'd1);

    // Flush loses a pending word.
    word_ready_i = 1'b0;
    send4(8'h5A, 8'h5A, 8'h5A, 8'h5A);
    check("lost_pending", 32'(word_valid_o), 32'd1);
    en_i = 1'b0;
    tick();
    check("lost_valid", 32'(word_valid_o), 32'd0);
    check("lost_addr", 32'(word_addr_o), 32'd0);
    en_i         = 1'b1;
    word_ready_i = 1'b1;
    tick();

    // Reset mid-word.
    send_byte(8'h99);
    send_byte(8'h88);
    rst_i = 1'b1;
    tick();
    check("mrst_valid", 32'(word_valid_o), 32'd0);
    check("mrst_data", word_data_o, 32'd0);
    check("mrst_addr", 32'(word_addr_o), 32'd0);
    rst_i = 1'b0;
    tick();
    push_exp(32'h4433_2211, 14'd0);
    send4(8'h11, 8'h22, 8'h33, 8'h44);
    tick();
    check("mrst_word_addr", 32'(word_addr_o), 32'd1);

    flush();
`ifdef UART_PACK_TIMEOUT_EN
    // A byte in the would-be timeout cycle wins.
    push_exp(32'hDDCC_BBAA, 14'd0);
    send_byte(8'hAA);
    send_byte(8'hBB);
    repeat (99) tick();
    send_byte(8'hCC);
    check("tmo_race", 32'(timeout_o), 32'd0);
    send_byte(8'hDD);
    tick();
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    repeat (99) tick();
    check("tmo_before", 32'(timeout_o), 32'd0);
    tick();
    check("tmo_fire", 32'(timeout_o), 32'd1);
    check("tmo_no_word", 32'(word_valid_o), 32'd0);
    push_exp(32'h4433_2211, 14'd1);
    send4(8'h11, 8'h22, 8'h33, 8'h44);
    tick();
    check("tmo_sticky", 32'(timeout_o), 32'd1);
`else
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    repeat (120) tick();
    check("notmo_flag", 32'(timeout_o), 32'd0);
    push_exp(32'h4433_2211, 14'd0);
    send_byte(8'h44);
    tick();
    check("notmo_flag2", 32'(timeout_o), 32'd0);
`endif

    repeat (5) tick();
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
